// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, depth and entry type for the writeback path
package mips_pkg;

    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-entry writeback queue exposing head and tail for forwarding
module wb_fifo
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output wb_entry_t        head,
    output wb_entry_t        tail
);

    wb_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tail is the most recently written slot; equals head when one entry is queued.
    assign head = mem[rd_ptr];
    assign tail = mem[wr_ptr - PTR_W'(1)];

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage: queues results, drains to RF; forwarding under WB_FORWARD_EN
module writeback_unit
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              rf_busy,
    output logic              rf_write_en,
    output logic [REG_W-1:0]  rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [REG_W-1:0]  fwd_addr1,
    input  logic [REG_W-1:0]  fwd_addr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [1:0]        pending_count
);

    logic [CNT_W-1:0] count;
    wb_entry_t        head;
    wb_entry_t        tail;
    wb_entry_t        push_entry;
    logic             accept;
    logic             push;
    logic             drain;

    assign in_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    // Results that never reach the register file still consume the handshake.
    assign push     = accept && in_reg_write && (in_rd != ZERO_REG);
    assign drain    = (count != '0) && !rf_busy;

    assign push_entry.rd   = in_rd;
    assign push_entry.data = in_mem_to_reg ? in_mem_data : in_alu_result;

    wb_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .count      (count),
        .head       (head),
        .tail       (tail)
    );

    assign pending_count = 2'(count);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write_en <= drain;
            if (drain) begin
                rf_write_addr <= head.rd;
                rf_write_data <= head.data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Newest value wins: tail, then the older head, then the write already on the RF port.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_W-1:0] addr);
        logic [DATA_W:0] r;
        r = '0;
        if (addr != ZERO_REG) begin
            if ((count != '0) && (tail.rd == addr)) begin
                r = {1'b1, tail.data};
            end else if ((count == CNT_W'(FIFO_DEPTH)) && (head.rd == addr)) begin
                r = {1'b1, head.data};
            end else if (rf_write_en && (rf_write_addr == addr)) begin
                r = {1'b1, rf_write_data};
            end
        end
        return r;
    endfunction

    assign {fwd_hit1, fwd_data1} = fwd_lookup(fwd_addr1);
    assign {fwd_hit2, fwd_data2} = fwd_lookup(fwd_addr2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr1, fwd_addr2, tail};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule
